// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and the word-addressed data memory.
// Handles sub-word loads with extension, sub-word stores via read-modify-write, and access faults.
module load_store_unit #(
    parameter int MEM_WORDS = 4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] loadData,
    output logic        fault,
    output logic        memWrEn,
    output logic [31:0] memAddr,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [2:0]  curOp;
    logic [1:0]  laneSel;
    logic [31:0] wrData;

    logic        misaligned;
    logic        outOfRange;
    logic        reqFault;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] extended;
    logic [31:0] mergedWord;

    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            OP_LW, OP_SW:         misaligned = |addr[1:0];
            default:              misaligned = 1'b0;
        endcase
        outOfRange = ({1'b0, addr} >= ADDR_LIMIT);
        reqFault   = misaligned | outOfRange;
    end

    always_comb begin
        selByte = memDataOut[7:0];
        case (laneSel)
            2'd0: selByte = memDataOut[7:0];
            2'd1: selByte = memDataOut[15:8];
            2'd2: selByte = memDataOut[23:16];
            2'd3: selByte = memDataOut[31:24];
            default: selByte = memDataOut[7:0];
        endcase
        selHalf = laneSel[1] ? memDataOut[31:16] : memDataOut[15:0];

        case (curOp)
            OP_LB:   extended = {{24{selByte[7]}}, selByte};
            OP_LBU:  extended = {24'd0, selByte};
            OP_LH:   extended = {{16{selHalf[15]}}, selHalf};
            OP_LHU:  extended = {16'd0, selHalf};
            default: extended = memDataOut;
        endcase
    end

    // The read issued in READ returns during WRITE, so the merge happens combinationally there.
    always_comb begin
        mergedWord = memDataOut;
        if (curOp == OP_SB) begin
            case (laneSel)
                2'd0: mergedWord[7:0]   = wrData[7:0];
                2'd1: mergedWord[15:8]  = wrData[7:0];
                2'd2: mergedWord[23:16] = wrData[7:0];
                2'd3: mergedWord[31:24] = wrData[7:0];
                default: mergedWord = memDataOut;
            endcase
        end else if (curOp == OP_SH) begin
            if (laneSel[1]) begin
                mergedWord[31:16] = wrData[15:0];
            end else begin
                mergedWord[15:0] = wrData[15:0];
            end
        end else begin
            mergedWord = wrData;
        end
        memDataIn = (state == WRITE) ? mergedWord : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            loadData <= 32'd0;
            memWrEn  <= 1'b0;
            memAddr  <= 32'd0;
            curOp    <= OP_LB;
            laneSel  <= 2'd0;
            wrData   <= 32'd0;
        end else begin
            done    <= 1'b0;
            memWrEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        curOp   <= op;
                        laneSel <= addr[1:0];
                        wrData  <= storeData;
                        memAddr <= {addr[31:2], 2'b00};
                        busy    <= 1'b1;
                        fault   <= reqFault;
                        if (reqFault) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (op == OP_SW) begin
                            state   <= WRITE;
                            memWrEn <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (curOp == OP_SB || curOp == OP_SH) begin
                        state   <= WRITE;
                        memWrEn <= 1'b1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    loadData <= extended;
                    state    <= DONE;
                    done     <= 1'b1;
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;

    localparam int MEM_WORDS = 4000;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] expLoad;
        logic        expFault;
        int          expLat;
        int          expWrites;
        logic [31:0] expWdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] storeData = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] loadData;
    logic        fault;
    logic        memWrEn;
    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    logic [31:0] mem [0:4095];

    int assertCount = 0;
    int failCount = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op         (op),
        .addr       (addr),
        .storeData  (storeData),
        .busy       (busy),
        .done       (done),
        .loadData   (loadData),
        .fault      (fault),
        .memWrEn    (memWrEn),
        .memAddr    (memAddr),
        .memDataIn  (memDataIn),
        .memDataOut (memDataOut)
    );

    always #5 clk = ~clk;

    // Registered-read data memory: dataOut reflects the address presented in the previous cycle.
    always @(posedge clk) begin
        if (memWrEn) mem[memAddr[13:2]] <= memDataIn;
        memDataOut <= mem[memAddr[13:2]];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request in IDLE and follows it until done or a cycle budget runs out.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                                 output int latency, output int writes,
                                 output logic [31:0] wdata, output int busyLow);
        latency = 0;
        writes  = 0;
        wdata   = 32'd0;
        busyLow = 0;
        @(negedge clk);
        req       = 1'b1;
        op        = o;
        addr      = a;
        storeData = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (!busy) busyLow++;
            if (memWrEn) begin
                writes++;
                wdata = memDataIn;
            end
            if (done) begin
                latency = cyc;
                break;
            end
        end
    endtask

    vec_t vecs [18];

    initial begin
        int lat;
        int wr;
        int bl;
        logic [31:0] wd;
        int doneCount;
        int lastDone;
        int busyLowCount;
        int writeCount;

        vecs[0]  = '{OP_SW,  32'h8,    32'hAABBCCDD, 32'h00000000, 1'b0, 2, 1, 32'hAABBCCDD};
        vecs[1]  = '{OP_LW,  32'h8,    32'h0,        32'hAABBCCDD, 1'b0, 3, 0, 32'h0};
        vecs[2]  = '{OP_LB,  32'h9,    32'h0,        32'hFFFFFFCC, 1'b0, 3, 0, 32'h0};
        vecs[3]  = '{OP_LBU, 32'hB,    32'h0,        32'h000000AA, 1'b0, 3, 0, 32'h0};
        vecs[4]  = '{OP_LH,  32'hA,    32'h0,        32'hFFFFAABB, 1'b0, 3, 0, 32'h0};
        vecs[5]  = '{OP_LHU, 32'h8,    32'h0,        32'h0000CCDD, 1'b0, 3, 0, 32'h0};
        vecs[6]  = '{OP_SB,  32'hA,    32'h12345677, 32'h0000CCDD, 1'b0, 3, 1, 32'hAA77CCDD};
        vecs[7]  = '{OP_SH,  32'h8,    32'h0000BEEF, 32'h0000CCDD, 1'b0, 3, 1, 32'hAA77BEEF};
        vecs[8]  = '{OP_LW,  32'h8,    32'h0,        32'hAA77BEEF, 1'b0, 3, 0, 32'h0};
        vecs[9]  = '{OP_LH,  32'h8,    32'h0,        32'hFFFFBEEF, 1'b0, 3, 0, 32'h0};
        vecs[10] = '{OP_LW,  32'h6,    32'h0,        32'hFFFFBEEF, 1'b1, 1, 0, 32'h0};
        vecs[11] = '{OP_SH,  32'h3,    32'h1111,     32'hFFFFBEEF, 1'b1, 1, 0, 32'h0};
        vecs[12] = '{OP_LB,  32'h3E80, 32'h0,        32'hFFFFBEEF, 1'b1, 1, 0, 32'h0};
        vecs[13] = '{OP_SW,  32'h3E7C, 32'h80000000, 32'hFFFFBEEF, 1'b0, 2, 1, 32'h80000000};
        vecs[14] = '{OP_LB,  32'h3E7F, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 32'h0};
        vecs[15] = '{OP_SB,  32'h3E7D, 32'h000000FF, 32'hFFFFFF80, 1'b0, 3, 1, 32'h8000FF00};
        vecs[16] = '{OP_LHU, 32'h3E7E, 32'h0,        32'h00008000, 1'b0, 3, 0, 32'h0};
        vecs[17] = '{OP_LW,  32'h8,    32'h0,        32'hAA77BEEF, 1'b0, 3, 0, 32'h0};

        #12;
        checkOutput("reset busy",      {31'd0, busy},    32'd0);
        checkOutput("reset done",      {31'd0, done},    32'd0);
        checkOutput("reset fault",     {31'd0, fault},   32'd0);
        checkOutput("reset loadData",  loadData,         32'd0);
        checkOutput("reset memWrEn",   {31'd0, memWrEn}, 32'd0);
        checkOutput("reset memAddr",   memAddr,          32'd0);
        checkOutput("reset memDataIn", memDataIn,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_SW, 32'h10, 32'h11223344, lat, wr, wd, bl);
        checkOutput("pre SW latency", 32'(lat), 32'd2);
        applyStimulus(OP_LW, 32'h10, 32'h0, lat, wr, wd, bl);
        checkOutput("pre LW loadData", loadData, 32'h11223344);

        // Abort an SB in its write cycle and confirm memory and outputs are untouched.
        @(negedge clk);
        req       = 1'b1;
        op        = OP_SB;
        addr      = 32'h11;
        storeData = 32'h00000055;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid-op memWrEn before reset", {31'd0, memWrEn}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-op reset memWrEn",   {31'd0, memWrEn}, 32'd0);
        checkOutput("mid-op reset busy",      {31'd0, busy},    32'd0);
        checkOutput("mid-op reset done",      {31'd0, done},    32'd0);
        checkOutput("mid-op reset loadData",  loadData,         32'd0);
        checkOutput("mid-op reset memDataIn", memDataIn,        32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid-op reset memory word", mem[4], 32'h11223344);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].sdata, lat, wr, wd, bl);
            checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].expFault});
            checkOutput($sformatf("v%0d loadData", i), loadData, vecs[i].expLoad);
            checkOutput($sformatf("v%0d write count", i), 32'(wr), 32'(vecs[i].expWrites));
            checkOutput($sformatf("v%0d busy low cycles", i), 32'(bl), 32'd0);
            if (vecs[i].expWrites != 0) begin
                checkOutput($sformatf("v%0d memDataIn", i), wd, vecs[i].expWdata);
            end
        end

        // req held high: two LW requests, separated by exactly one IDLE cycle.
        doneCount    = 0;
        lastDone     = 0;
        busyLowCount = 0;
        writeCount   = 0;
        @(negedge clk);
        req  = 1'b1;
        op   = OP_LW;
        addr = 32'h8;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                lastDone = cyc;
            end
            if (!busy) busyLowCount++;
            if (memWrEn) writeCount++;
        end
        req = 1'b0;
        for (int cyc = 8; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (done) doneCount++;
            if (memWrEn) writeCount++;
        end
        checkOutput("held req done count",     32'(doneCount),    32'd2);
        checkOutput("held req second done",    32'(lastDone),     32'd7);
        checkOutput("held req busy low cycles", 32'(busyLowCount), 32'd1);
        checkOutput("held req writes",         32'(writeCount),   32'd0);
        checkOutput("held req loadData",       loadData,          32'hAA77BEEF);
        checkOutput("held req idle busy",      {31'd0, busy},     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
